// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/operand/result bundle between requesters and the shared adder
interface add_arbiter_if #(parameter int WIDTH = 32);
   logic [2:0]         req;
   logic [3*WIDTH-1:0] opa;
   logic [3*WIDTH-1:0] opb;
   logic [2:0]         gnt;
   logic [2:0]         done;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic               busy;
   modport master (output req, opa, opb, input gnt, done, sum, cout, busy);
   modport slave  (input req, opa, opb, output gnt, done, sum, cout, busy);
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: one shared adder serving three requesters round-robin via IDLE/CALC/DONE
module add_arbiter #(parameter int WIDTH = 32) (
   input logic         clk,
   input logic         rst_n,
   add_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       state_q, state_d, ptr_q, ptr_d, win, c1, c2;
   logic [2:0]       elig, gnt_q, gnt_d, done_q, done_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             cout_q, cout_d;
   // eligible requesters (just-served one masked in DONE) and round-robin winner from ptr
   always_comb begin
      elig = bus.req & ((state_q == DONE) ? ~done_q : 3'b111);
      c1   = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
      c2   = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
      win  = elig[ptr_q] ? ptr_q : elig[c1] ? c1 : c2;
   end
   // next-state: grant and latch operands from IDLE/DONE, add latched operands in CALC
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = 3'b000;
      done_d  = 3'b000;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (state_q == CALC) begin
         {cout_d, sum_d} = {1'b0, a_q} + {1'b0, b_q};
         done_d  = gnt_q;
         state_d = DONE;
      end else if (|elig) begin
         a_d     = (win == 2'd2) ? bus.opa[2*WIDTH +: WIDTH] : (win == 2'd1) ? bus.opa[WIDTH +: WIDTH] : bus.opa[0 +: WIDTH];
         b_d     = (win == 2'd2) ? bus.opb[2*WIDTH +: WIDTH] : (win == 2'd1) ? bus.opb[WIDTH +: WIDTH] : bus.opb[0 +: WIDTH];
         gnt_d   = 3'b001 << win;
         ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
         state_d = CALC;
      end else begin
         state_d = IDLE;
      end
   end
   // state registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         gnt_q   <= 3'b000;
         done_q  <= 3'b000;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
   assign bus.gnt  = gnt_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed table, corner sequences and randomized run against a transaction model
module tb_add_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   add_arbiter_if #(.WIDTH(32)) bus ();
   add_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  req;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  gnt;
      logic [31:0] sum;
      logic        cout;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   int m_calc, m_last, m_ptr;
   logic [31:0] m_a, m_b, e_sum;
   logic [2:0]  e_gnt, e_done;
   logic        e_cout, e_busy;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_calc = -1; m_last = -1; m_ptr = 0;
      m_a = '0; m_b = '0; e_sum = '0;
      e_gnt = '0; e_done = '0; e_cout = 1'b0; e_busy = 1'b0;
   endtask

   // one transaction-level step: finish a pending addition, otherwise pick the next requester
   task automatic model_step();
      logic [32:0] s;
      e_gnt = '0;
      if (m_calc >= 0) begin
         s = {1'b0, m_a} + {1'b0, m_b};
         e_sum = s[31:0];
         e_cout = s[32];
         e_done = 3'(1 << m_calc);
         m_last = m_calc;
         m_calc = -1;
      end else begin
         e_done = '0;
         for (int i = 0; i < 3; i++) begin
            int k;
            k = (m_ptr + i) % 3;
            if (m_calc < 0 && bus.req[k] && k != m_last) begin
               m_calc = k;
               m_a = bus.opa[32*k +: 32];
               m_b = bus.opb[32*k +: 32];
               e_gnt = 3'(1 << k);
            end
         end
         if (m_calc >= 0) m_ptr = (m_calc + 1) % 3;
         m_last = -1;
      end
      e_busy = (m_calc >= 0) || (e_done != 0);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_gnt"},  64'(bus.gnt),  64'(e_gnt));
      chk({tag, "_done"}, 64'(bus.done), 64'(e_done));
      chk({tag, "_sum"},  64'(bus.sum),  64'(e_sum));
      chk({tag, "_cout"}, 64'(bus.cout), 64'(e_cout));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(e_busy));
      chk({tag, "_onehot"}, 64'($onehot0(bus.gnt) && $onehot0(bus.done)), 64'(1));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all("cyc");
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   vec_t tbl[6];
   logic [2:0] gq[$];

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3'b001, 32'd5,          32'd7,          3'b001, 32'd12,         1'b0};
      tbl[1] = '{3'b010, 32'hFFFFFFFF,   32'h00000001,   3'b010, 32'h00000000,   1'b1};
      tbl[2] = '{3'b100, 32'h80000000,   32'h80000000,   3'b100, 32'h00000000,   1'b1};
      tbl[3] = '{3'b001, 32'h12345678,   32'h11111111,   3'b001, 32'h23456789,   1'b0};
      tbl[4] = '{3'b010, 32'h00000000,   32'h00000000,   3'b010, 32'h00000000,   1'b0};
      tbl[5] = '{3'b100, 32'hFFFFFFFF,   32'hFFFFFFFF,   3'b100, 32'hFFFFFFFE,   1'b1};
      bus.req = '0; bus.opa = '0; bus.opb = '0;
      #1;
      do_reset();

      foreach (tbl[i]) begin
         bus.req = tbl[i].req;
         bus.opa = {3{tbl[i].a}};
         bus.opb = {3{tbl[i].b}};
         tick();
         chk("tbl_gnt", 64'(bus.gnt), 64'(tbl[i].gnt));
         bus.req = '0;
         bus.opa = {$urandom, $urandom, $urandom};
         tick();
         chk("tbl_done", 64'(bus.done), 64'(tbl[i].gnt));
         chk("tbl_sum",  64'(bus.sum),  64'(tbl[i].sum));
         chk("tbl_cout", 64'(bus.cout), 64'(tbl[i].cout));
         tick();
         chk("tbl_idle", 64'({bus.busy, bus.done}), 64'(0));
      end

      do_reset();
      bus.req = 3'b111;
      bus.opa = {32'h30000003, 32'h20000002, 32'h10000001};
      bus.opb = {32'h00000300, 32'h00000200, 32'h00000100};
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.gnt != 0) gq.push_back(bus.gnt);
      end
      chk("rr_count", 64'(gq.size()), 64'(4));
      if (gq.size() == 4) begin
         chk("rr_g0", 64'(gq[0]), 64'(3'b001));
         chk("rr_g1", 64'(gq[1]), 64'(3'b010));
         chk("rr_g2", 64'(gq[2]), 64'(3'b100));
         chk("rr_g3", 64'(gq[3]), 64'(3'b001));
      end

      bus.req = '0;
      do_reset();
      bus.req = 3'b100;
      bus.opa = {32'h11111111, 64'h0};
      bus.opb = {32'h22222222, 64'h0};
      tick();
      chk("opchg_gnt", 64'(bus.gnt), 64'(3'b100));
      bus.opa = {32'hDEADBEEF, 64'h0};
      bus.req = '0;
      tick();
      chk("opchg_done", 64'(bus.done), 64'(3'b100));
      chk("opchg_sum",  64'(bus.sum),  64'(32'h33333333));

      do_reset();
      bus.req = 3'b001;
      bus.opa = {32'd3, 32'd2, 32'd1};
      bus.opb = {32'd30, 32'd20, 32'd10};
      tick();
      chk("abort_gnt", 64'(bus.gnt), 64'(3'b001));
      bus.req = 3'b100;
      do_reset();
      chk("abort_zero", 64'({bus.gnt, bus.done, bus.sum, bus.cout, bus.busy}), 64'(0));
      tick();
      chk("abort_next_gnt", 64'(bus.gnt), 64'(3'b100));
      bus.req = '0;
      tick();
      chk("abort_next_done", 64'(bus.done), 64'(3'b100));
      chk("abort_next_sum",  64'(bus.sum),  64'(32'd33));

      do_reset();
      for (int i = 0; i < 600; i++) begin
         bus.req = 3'($urandom_range(0, 7));
         for (int k = 0; k < 3; k++) begin
            bus.opa[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            bus.opb[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
         end
         if ($urandom_range(0, 79) == 0) do_reset();
         else tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; behaviour is defined for WIDTH=32 only.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  3  per-requester add request, level; bit k = requester k.
REQ-005 Port: opa  input  96  operand A, requester k at bits [32k+31:32k].
REQ-006 Port: opb  input  96  operand B, same packing as opa.
REQ-007 Port: gnt  output  3  registered one-hot grant, high for the CALC cycle of the winner.
REQ-008 Port: done  output  3  registered one-hot completion pulse, one cycle, bit of the served requester.
REQ-009 Port: sum  output  32  registered result A+B mod 2^32, valid while done is non-zero; held otherwise.
REQ-010 Port: cout  output  1  registered carry-out of the same addition.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The block SHALL share one 32-bit adder among three requesters through an FSM with states IDLE, CALC, DONE.
REQ-013 In IDLE or DONE, if any eligible req bit is set, the block SHALL pick a winner round-robin, latch its opa/opb slices into internal registers, set gnt to the winner's one-hot and enter CALC at the next edge.
REQ-014 Eligible = req[k] set and, in DONE, done[k] clear; the requester just served is masked for that one cycle.
REQ-015 Round-robin: search starts at pointer ptr, wraps 2->0; on each grant ptr SHALL become (winner+1) mod 3.
REQ-016 In CALC the adder SHALL operate on the latched operands only; at the next edge sum/cout are registered, done<=gnt, gnt<=0, state<=DONE.
REQ-017 In DONE with no eligible request the block SHALL return to IDLE; done clears at that edge in all cases.
REQ-018 Latency: req sampled in IDLE at cycle N -> gnt in N+1 -> done and sum in N+2; back-to-back service SHALL give one result every 2 cycles.
REQ-019 Operands are latched at the grant edge; changes to opa/opb or deassertion of req after that edge SHALL NOT affect the result, and done SHALL still pulse.
REQ-020 Requests arriving while in CALC SHALL be held pending (level req) and considered in DONE.
REQ-021 Overflow wraps: 0xFFFFFFFF+0x00000001 SHALL give sum=0x00000000, cout=1.
REQ-022 gnt and done SHALL each be one-hot or zero; never more than one bit high.

Reset
REQ-023 While rst_n=0: state=IDLE, ptr=0, gnt=0, done=0, sum=0, cout=0, busy=0, operand registers 0, applied immediately regardless of clk.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse for it after release.
REQ-025 First edge after rst_n rises SHALL perform normal IDLE arbitration.

Verification
REQ-026 Single: req=001, opa[31:0]=5, opb[31:0]=7 -> gnt=001 at N+1, done=001 and sum=12, cout=0 at N+2, busy low at N+3.
REQ-027 Wrap: req=010, slice1 A=0xFFFFFFFF, B=1 -> done=010, sum=0, cout=1.
REQ-028 Contention: req=111 held from reset -> grants in order 001,010,100,001, one done every 2 cycles, each sum matching its own slices.
REQ-029 Operand change: requester 2 changes opa and drops req the cycle after grant -> sum uses originally latched values, done=100 still pulses.
REQ-030 Reset in CALC: rst_n low for 1 cycle while gnt=001 -> all outputs 0 immediately, no done afterward, next req=100 granted first (ptr=0 search order 0,1,2).
